// File: rtl/lcv_div_iter_del_if.sv
// lcv_div_iter_del_if: request/result handshake bundle for the iterative divider.
//   inp_valid/inp_ready    request handshake
//   inp_a, inp_b           dividend, divisor (WIDTH bits)
//   inp_signed             1 = two's-complement operands
//   outp_valid/outp_ready  result handshake
//   outp_quot, outp_rem    quotient, remainder (WIDTH bits)
//   outp_div_by_zero       divisor was zero
// master = requester/consumer side, slave = divider side.
interface lcv_div_iter_del_if #(
   parameter int unsigned WIDTH = 32
);
   logic             inp_valid;
   logic             inp_ready;
   logic [WIDTH-1:0] inp_a;
   logic [WIDTH-1:0] inp_b;
   logic             inp_signed;
   logic             outp_valid;
   logic             outp_ready;
   logic [WIDTH-1:0] outp_quot;
   logic [WIDTH-1:0] outp_rem;
   logic             outp_div_by_zero;

   modport master (
      output inp_valid, inp_a, inp_b, inp_signed, outp_ready,
      input  inp_ready, outp_valid, outp_quot, outp_rem, outp_div_by_zero
   );

   modport slave (
      input  inp_valid, inp_a, inp_b, inp_signed, outp_ready,
      output inp_ready, outp_valid, outp_quot, outp_rem, outp_div_by_zero
   );
endinterface

// File: rtl/lcv_div_iter_del.sv
// lcv_div_iter_del: iterative radix-2 restoring divider (DIV/REM unit).
// One request is accepted in IDLE, WIDTH iterations resolve one quotient bit
// each, a fix-up cycle applies sign correction, and the result is held until
// the consumer takes it. Latency accept-to-valid is WIDTH+1 cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  lcv_div_iter_del_if.slave (request and result handshakes)
module lcv_div_iter_del #(
   parameter int unsigned WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   lcv_div_iter_del_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd;     // dividend magnitude shifts out, quotient bits shift in
   logic [WIDTH-1:0] dvs;     // divisor magnitude
   logic [WIDTH-1:0] rem;     // partial remainder
   logic [CW-1:0]    cnt;
   logic             neg_q;
   logic             neg_r;
   logic             dbz;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_sh;
   logic             borrow;
   logic [WIDTH-1:0] rem_next;

   always_comb begin
      a_neg  = bus.inp_signed & bus.inp_a[WIDTH-1];
      b_neg  = bus.inp_signed & bus.inp_b[WIDTH-1];
      a_mag  = a_neg ? -bus.inp_a : bus.inp_a;
      b_mag  = b_neg ? -bus.inp_b : bus.inp_b;
      rem_sh = {rem, dvd[WIDTH-1]};
      // Borrow from the WIDTH+1 bit trial subtraction; when there is no
      // borrow the difference is below the divisor, so WIDTH bits hold it.
      borrow   = rem_sh < {1'b0, dvs};
      rem_next = borrow ? rem_sh[WIDTH-1:0] : rem_sh[WIDTH-1:0] - dvs;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         dvd                  <= '0;
         dvs                  <= '0;
         rem                  <= '0;
         cnt                  <= '0;
         neg_q                <= 1'b0;
         neg_r                <= 1'b0;
         dbz                  <= 1'b0;
         bus.inp_ready        <= 1'b1;
         bus.outp_valid       <= 1'b0;
         bus.outp_quot        <= '0;
         bus.outp_rem         <= '0;
         bus.outp_div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.inp_valid) begin
                  dvd           <= a_mag;
                  dvs           <= b_mag;
                  rem           <= '0;
                  cnt           <= CW'(WIDTH - 1);
                  neg_q         <= bus.inp_signed
                                   && (bus.inp_a[WIDTH-1] != bus.inp_b[WIDTH-1])
                                   && (bus.inp_b != '0);
                  neg_r         <= a_neg;
                  dbz           <= (bus.inp_b == '0);
                  bus.inp_ready <= 1'b0;
                  state         <= ITER;
               end
            end
            ITER: begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], ~borrow};
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               bus.outp_quot        <= neg_q ? -dvd : dvd;
               bus.outp_rem         <= neg_r ? -rem : rem;
               bus.outp_div_by_zero <= dbz;
               bus.outp_valid       <= 1'b1;
               state                <= DONE;
            end
            DONE: begin
               if (bus.outp_ready) begin
                  bus.outp_valid <= 1'b0;
                  bus.inp_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lcv_div_iter_del.sv
// tb_lcv_div_iter_del: scoreboard bench for lcv_div_iter_del (WIDTH=32).
// The driver pushes expected results computed with plain integer division;
// the monitor pops and compares whenever a result is handed over.
module tb_lcv_div_iter_del;
   localparam int unsigned W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int unsigned  acc;
   } exp_t;

   logic        clk;
   logic        rst;
   int unsigned cyc = 0;
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned rdy_mode = 0;   // 0 ready high, 1 random, 2 held low
   int unsigned rst_req = 0;
   int unsigned rst_seen = 0;
   exp_t        sb[$];

   lcv_div_iter_del_if #(.WIDTH(W)) bus ();

   lcv_div_iter_del #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.outp_ready = 1'b1;
         1:       bus.outp_ready = 1'($urandom_range(0, 1));
         default: bus.outp_ready = 1'b0;
      endcase
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s);
      exp_t   e;
      longint sa;
      longint sb_;
      e.acc = 0;
      e.z   = (b == 0);
      if (b == 0) begin
         e.q = '1;
         e.r = a;
      end else if (s) begin
         sa  = longint'($signed(a));
         sb_ = longint'($signed(b));
         e.q = W'(sa / sb_);
         e.r = W'(sa % sb_);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Monitor: all comparisons are made here.
   logic prev_valid = 1'b0;
   logic post_hs    = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_valid = 1'b0;
         post_hs    = 1'b0;
      end else begin
         if (rst_req != rst_seen) begin
            rst_seen = rst_req;
            checks++;
            if ({bus.inp_ready, bus.outp_valid, bus.outp_div_by_zero,
                 bus.outp_quot, bus.outp_rem} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}) begin
               errors++;
               $display("FAIL reset_state: got rdy=%b vld=%b dbz=%b q=%h r=%h expected rdy=1 vld=0 dbz=0 q=0 r=0",
                        bus.inp_ready, bus.outp_valid, bus.outp_div_by_zero,
                        bus.outp_quot, bus.outp_rem);
            end
         end
         if (post_hs) begin
            post_hs = 1'b0;
            checks++;
            if (bus.outp_valid !== 1'b0 || bus.inp_ready !== 1'b1) begin
               errors++;
               $display("FAIL post_handshake: got vld=%b rdy=%b expected vld=0 rdy=1",
                        bus.outp_valid, bus.inp_ready);
            end
         end
         if (bus.outp_valid === 1'b1) begin
            checks++;
            if (bus.inp_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_while_busy: got inp_ready=%b expected 0", bus.inp_ready);
            end
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got outp_valid=1 expected no pending result");
            end else begin
               e = sb[0];
               if (!prev_valid) begin
                  checks++;
                  if (cyc - e.acc != W + 1) begin
                     errors++;
                     $display("FAIL latency: got %0d cycles expected %0d", cyc - e.acc, W + 1);
                  end
               end
               checks++;
               if (bus.outp_quot !== e.q || bus.outp_rem !== e.r
                   || bus.outp_div_by_zero !== e.z) begin
                  errors++;
                  $display("FAIL result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                           bus.outp_quot, bus.outp_rem, bus.outp_div_by_zero, e.q, e.r, e.z);
               end
               if (bus.outp_ready === 1'b1) begin
                  void'(sb.pop_front());
                  post_hs = 1'b1;
               end
            end
         end
         prev_valid = (bus.outp_valid === 1'b1) && (bus.outp_ready !== 1'b1);
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit push);
      exp_t        e;
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (bus.inp_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.inp_ready !== 1'b1) begin
         $display("FAIL accept_timeout: got inp_ready=%b expected 1 within 300 cycles", bus.inp_ready);
         $fatal(1, "accept timeout");
      end
      bus.inp_a      = a;
      bus.inp_b      = b;
      bus.inp_signed = s;
      bus.inp_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.inp_valid  = 1'b0;
      // Scramble operands after the accept edge; they must be ignored.
      bus.inp_a      = $urandom;
      bus.inp_b      = $urandom;
      bus.inp_signed = 1'($urandom_range(0, 1));
      if (push) begin
         e     = model(a, b, s);
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int unsigned  n;
      rst            = 1'b1;
      bus.inp_valid  = 1'b0;
      bus.inp_a      = '0;
      bus.inp_b      = '0;
      bus.inp_signed = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      rst_req++;

      issue(32'd100,       32'd7,        1'b0, 1'b1);
      issue(32'hFFFFFFF9,  32'd2,        1'b1, 1'b1);
      issue(32'd7,         32'hFFFFFFFE, 1'b1, 1'b1);
      issue(32'd5,         32'd0,        1'b0, 1'b1);
      issue(32'hFFFFFFFB,  32'd0,        1'b1, 1'b1);
      issue(32'h80000000,  32'hFFFFFFFF, 1'b1, 1'b1);
      issue(32'hFFFFFFFF,  32'd1,        1'b0, 1'b1);

      // Backpressure: hold outp_ready low for 10 cycles of valid.
      @(negedge clk);
      while (bus.inp_ready !== 1'b1) @(negedge clk);
      rdy_mode = 2;
      issue(32'd1234567, 32'd89, 1'b0, 1'b1);
      n = 0;
      while (bus.outp_valid !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.outp_valid !== 1'b1) begin
         $display("FAIL valid_timeout: got outp_valid=%b expected 1", bus.outp_valid);
         $fatal(1, "valid timeout");
      end
      repeat (10) @(negedge clk);
      rdy_mode = 0;

      // Abort mid-iteration with rst.
      issue(32'd4321, 32'd3, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      rst_req++;
      issue(32'd1000, 32'd10, 1'b0, 1'b1);

      // Random traffic with random consumer backpressure.
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 16));
            2:       rb = '1;
            3:       begin ra = 32'h80000000; rb = $urandom; end
            default: rb = $urandom;
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      end

      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
         $fatal(1, "drain timeout");
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
